alu_issue_wb: RTL and testbench
===============================

// Module: alu_issue_wb
// PURPOSE
//  Issue/writeback stage wrapped around the 8-bit ALU: holds the 8-entry register file and the flag register.
//  Accepts one instruction (op, rd, rs1, rs2/imm) per valid/ready handshake and drives the ALU operands and opcode.
//  Captures the ALU result, zero and ovr outputs, then writes the result to rd and updates the flags.
//  Non-pipelined FSM: one instruction in flight; sits between the instruction decoder (upstream) and the ALU.
// PARAMETERS
//  DATA_W   8   datapath width; must match ALU a/b/result
//  NREGS    8   register-file entries
//  REG_AW   3   register index width, = log2(NREGS)
// PORTS
//  clk          in   1       single clock, all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       instruction present on in_* this cycle
//  in_ready     out  1       stage can accept; transfer when in_valid & in_ready at clk edge
//  in_op        in   3       ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 slt(unsigned), 101 eq; 110/111 illegal
//  in_rd        in   REG_AW  destination register
//  in_rs1       in   REG_AW  source register for ALU a
//  in_rs2       in   REG_AW  source register for ALU b (when in_use_imm=0)
//  in_use_imm   in   1       1: ALU b = in_imm, 0: ALU b = rf[in_rs2]
//  in_imm       in   DATA_W  immediate operand
//  alu_a        out  DATA_W  to ALU a
//  alu_b        out  DATA_W  to ALU b
//  alu_instr    out  3       to ALU ALU_instr
//  alu_result   in   DATA_W  from ALU result (combinational)
//  alu_zero     in   1       from ALU zero
//  alu_ovr      in   1       from ALU ovr (carry-out of add)
//  dbg_rd_addr  in   REG_AW  debug read index
//  dbg_rd_data  out  DATA_W  combinational rf[dbg_rd_addr]; 0 for index 0
//  flag_zero    out  1       registered zero flag
//  flag_ovr     out  1       registered overflow flag
//  done         out  1       1-cycle pulse: writeback completed
//  illegal      out  1       1-cycle pulse: illegal opcode dropped
// BEHAVIOUR
//  Reset: state IDLE; all registers, latched instruction, result reg, flag_zero, flag_ovr, done, illegal = 0.
//  Reset has priority over everything; reset mid-operation aborts it with no rf/flag write and no done.
//  States: IDLE -> EXEC -> WB -> IDLE. in_ready = (state==IDLE); in_* ignored in other states.
//  IDLE: on in_valid, latch op/rd/rs1/rs2/use_imm/imm (edge E0), go to EXEC.
//  EXEC (cycle after E0): alu_a = rf[rs1], alu_b = use_imm ? imm : rf[rs2], alu_instr = op.
//    op in {110,111}: at E1 go to IDLE, illegal=1 for the cycle after E1, no write, flags unchanged.
//    otherwise: at E1 capture alu_result, alu_zero, alu_ovr into the result reg and go to WB.
//  WB: at E2, write result to rd (ignored if rd==0); flag_zero <= captured zero;
//    flag_ovr <= captured ovr if op==000, else 0. Go to IDLE; done=1 for the cycle after E2.
//  Latency: accept at E0 -> new rf/flags visible and done high in the cycle after E2; next accept at E3 at the earliest.
//  Register 0 reads as 0 on every read path and is never written; flags still update for rd==0.
//  Outside EXEC: alu_a, alu_b and alu_instr = 0.
//  Arithmetic is DATA_W-bit and wraps; stage takes no part in ALU computation.
//  rs1/rs2 equal to the previous rd see the written value (written at E2, before the next EXEC).
// TESTING
//  1. rst, ADD rd=1 rs1=0 imm=0x05 -> done after 3 cycles, dbg r1=0x05, Z=0, O=0.
//  2. load r1=0xF0, r2=0x20; ADD r3=r1+r2 -> r3=0x10, O=1, Z=0; following OR r4=r3|imm 0x01 -> O=0.
//  3. SUB r4=r1-r1 -> r4=0x00, Z=1; SLT r5=r2<r1 -> 0x01; EQ r6=r1==r2 -> 0x00, Z=1.
//  4. ADD rd=0 rs1=0 imm=0x7F -> dbg r0 reads 0x00, Z=0, done pulses.
//  5. op=110 -> illegal high 1 cycle, no done, all regs and flags unchanged, in_ready high 2 cycles after accept.
//  6. in_valid held high throughout: accepts only every 3rd cycle; rst during EXEC -> rd not written, flags 0.

Source files
------------

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around the 8-bit ALU with register file and flags; accept at E0, rf/flags/done visible after E2.
// in_ready only in IDLE, so one instruction is in flight and the next accept comes at E3 at the earliest.
module alu_issue_wb #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_instr,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_ovr,
  input  logic [REG_AW-1:0] dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic              flag_zero,
  output logic              flag_ovr,
  output logic              done,
  output logic              illegal
);

  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
  } instr_t;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;

  state_t            state, state_nxt;
  instr_t            instr_q;
  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              ovr_q;
  logic              op_bad;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  // Opcodes 110 and 111 are the only illegal encodings.
  assign op_bad  = instr_q.op[2] & instr_q.op[1];
  assign rs1_val = (instr_q.rs1 == '0) ? '0 : rf[instr_q.rs1];
  assign rs2_val = (instr_q.rs2 == '0) ? '0 : rf[instr_q.rs2];
  assign dbg_rd_data = (dbg_rd_addr == '0) ? '0 : rf[dbg_rd_addr];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_instr = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        alu_a     = rs1_val;
        alu_b     = instr_q.use_imm ? instr_q.imm : rs2_val;
        alu_instr = instr_q.op;
        state_nxt = op_bad ? IDLE : WB;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      instr_q   <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovr_q     <= 1'b0;
      flag_zero <= 1'b0;
      flag_ovr  <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      state   <= state_nxt;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            instr_q.op      <= in_op;
            instr_q.rd      <= in_rd;
            instr_q.rs1     <= in_rs1;
            instr_q.rs2     <= in_rs2;
            instr_q.use_imm <= in_use_imm;
            instr_q.imm     <= in_imm;
          end
        end
        EXEC: begin
          if (op_bad) begin
            illegal <= 1'b1;
          end else begin
            res_q  <= alu_result;
            zero_q <= alu_zero;
            ovr_q  <= alu_ovr;
          end
        end
        WB: begin
          // Flags update even when the write to r0 is discarded.
          if (instr_q.rd != '0) rf[instr_q.rd] <= res_q;
          flag_zero <= zero_q;
          flag_ovr  <= (instr_q.op == OP_ADD) & ovr_q;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: ALU stand-in plus directed and random instructions scored against an abstract register/flag model.
module tb_alu_issue_wb;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic       in_use_imm;
  logic [7:0] in_imm;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_instr;
  logic [7:0] alu_result;
  logic       alu_zero, alu_ovr;
  logic [2:0] dbg_rd_addr;
  logic [7:0] dbg_rd_data;
  logic       flag_zero, flag_ovr, done, illegal;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [7:0] ref_rf [8];
  logic       ref_z, ref_o;

  always #5 clk = ~clk;

  alu_issue_wb dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_instr(alu_instr),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovr(alu_ovr),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .flag_zero(flag_zero), .flag_ovr(flag_ovr), .done(done), .illegal(illegal)
  );

  // ALU stand-in; ovr carries the sub borrow and junk on illegal ops so the stage's masking is exercised.
  logic [8:0] alu_s;
  always_comb begin
    alu_s      = '0;
    alu_result = '0;
    alu_ovr    = 1'b0;
    case (alu_instr)
      3'd0: begin alu_s = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = alu_s[7:0]; alu_ovr = alu_s[8]; end
      3'd1: begin alu_s = {1'b0, alu_a} - {1'b0, alu_b}; alu_result = alu_s[7:0]; alu_ovr = alu_s[8]; end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = {7'd0, alu_a < alu_b};
      3'd5: alu_result = {7'd0, alu_a == alu_b};
      default: begin alu_result = 8'hA5; alu_ovr = 1'b1; end
    endcase
    alu_zero = (alu_result == 8'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rd_ref(input int idx);
    return (idx == 0) ? 0 : int'(ref_rf[idx]);
  endfunction

  // Architectural effect of one instruction, computed with plain integer arithmetic.
  task automatic ref_apply(input int op, input int rd, input int rs1, input int rs2,
                           input int use_imm, input int imm);
    int a, b, r;
    bit o;
    a = rd_ref(rs1);
    b = use_imm ? imm : rd_ref(rs2);
    o = 0;
    case (op)
      0: begin r = (a + b) % 256; o = (a + b) > 255; end
      1: r = (a - b + 256) % 256;
      2: r = a & b;
      3: r = a | b;
      4: r = (a < b) ? 1 : 0;
      5: r = (a == b) ? 1 : 0;
      default: return;
    endcase
    if (rd != 0) ref_rf[rd] = 8'(r);
    ref_z = (r == 0);
    ref_o = o;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_rd_addr = 3'(i);
      #1;
      check($sformatf("rf%0d", i), 32'(dbg_rd_data), 32'(rd_ref(i)));
    end
  endtask

  task automatic peek(input int idx, output logic [7:0] v);
    dbg_rd_addr = 3'(idx);
    #1;
    v = dbg_rd_data;
  endtask

  task automatic do_instr(input int op, input int rd, input int rs1, input int rs2,
                          input int use_imm, input int imm);
    int ea, eb;
    bit bad;
    bad = (op >= 6);
    ea  = rd_ref(rs1);
    eb  = use_imm ? imm : rd_ref(rs2);
    @(negedge clk);
    check("rdy_idle", 32'(in_ready), 1);
    check("pulse_low", 32'({done, illegal}), 0);
    in_valid = 1'b1; in_op = 3'(op); in_rd = 3'(rd); in_rs1 = 3'(rs1);
    in_rs2 = 3'(rs2); in_use_imm = 1'(use_imm); in_imm = 8'(imm);
    @(negedge clk);
    in_valid = 1'b0;
    in_op = 3'($urandom); in_rd = 3'($urandom); in_rs1 = 3'($urandom);
    in_rs2 = 3'($urandom); in_use_imm = 1'($urandom); in_imm = 8'($urandom);
    check("exec_a", 32'(alu_a), 32'(ea));
    check("exec_b", 32'(alu_b), 32'(eb));
    check("exec_op", 32'(alu_instr), 32'(op));
    check("exec_rdy", 32'(in_ready), 0);
    @(negedge clk);
    check("post_exec_a", 32'(alu_a), 0);
    check("post_exec_ill", 32'(illegal), 32'(bad));
    check("post_exec_done", 32'(done), 0);
    check("post_exec_rdy", 32'(in_ready), 32'(bad));
    if (!bad) begin
      @(negedge clk);
      ref_apply(op, rd, rs1, rs2, use_imm, imm);
      check("wb_done", 32'(done), 1);
      check("wb_ill", 32'(illegal), 0);
      check("wb_rdy", 32'(in_ready), 1);
    end
    check("flag_z", 32'(flag_zero), 32'(ref_z));
    check("flag_o", 32'(flag_ovr), 32'(ref_o));
    check_regs();
  endtask

  initial begin
    logic [7:0] v;
    int dones, rdys;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_use_imm = 1'b0; in_imm = '0; dbg_rd_addr = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    ref_z = 1'b0; ref_o = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_rdy", 32'(in_ready), 1);
    check("rst_done", 32'({done, illegal}), 0);
    check("rst_flags", 32'({flag_zero, flag_ovr}), 0);
    check("rst_alu", 32'({alu_a, alu_b, alu_instr}), 0);
    check_regs();

    // ADD r1 = r0 + 0x05
    do_instr(0, 1, 0, 0, 1, 8'h05);
    peek(1, v); check("t1_r1", 32'(v), 32'h05);
    check("t1_zo", 32'({flag_zero, flag_ovr}), 0);

    // Carry-out then a non-add op clearing the overflow flag
    do_instr(0, 1, 0, 0, 1, 8'hF0);
    do_instr(0, 2, 0, 0, 1, 8'h20);
    do_instr(0, 3, 1, 2, 0, 0);
    peek(3, v); check("t2_r3", 32'(v), 32'h10);
    check("t2_zo", 32'({flag_zero, flag_ovr}), 32'b01);
    do_instr(3, 4, 3, 0, 1, 8'h01);
    check("t2_or_o", 32'(flag_ovr), 0);

    // SUB / SLT / EQ
    do_instr(1, 4, 1, 1, 0, 0);
    peek(4, v); check("t3_r4", 32'(v), 0);
    check("t3_sub_z", 32'(flag_zero), 1);
    do_instr(4, 5, 2, 1, 0, 0);
    peek(5, v); check("t3_r5", 32'(v), 32'h01);
    do_instr(5, 6, 1, 2, 0, 0);
    peek(6, v); check("t3_r6", 32'(v), 0);
    check("t3_eq_z", 32'(flag_zero), 1);

    // Illegal opcodes leave everything untouched
    do_instr(6, 3, 1, 2, 1, 8'h11);
    do_instr(7, 1, 1, 1, 0, 0);
    check("t5_z_kept", 32'(flag_zero), 1);

    // Write to r0 is dropped, flags still update
    do_instr(0, 0, 0, 0, 1, 8'h7F);
    peek(0, v); check("t4_r0", 32'(v), 0);
    check("t4_z", 32'(flag_zero), 0);

    // in_valid held high: one accept every third cycle
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_rd = 3'd1; in_rs1 = 3'd1; in_rs2 = 3'd0;
    in_use_imm = 1'b1; in_imm = 8'h01;
    dones = 0; rdys = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      dones += int'(done);
      rdys  += int'(in_ready);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) ref_apply(0, 1, 1, 0, 1, 1);
    check("t6_dones", 32'(dones), 3);
    check("t6_rdys", 32'(rdys), 3);
    check_regs();

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    check("t6_rdy", 32'(in_ready), 1);
    in_valid = 1'b1; in_op = 3'd0; in_rd = 3'd2; in_rs1 = 3'd1; in_use_imm = 1'b1; in_imm = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    ref_z = 1'b0; ref_o = 1'b0;
    check("t6_rst_rdy", 32'(in_ready), 1);
    check("t6_rst_flags", 32'({flag_zero, flag_ovr}), 0);
    for (int c = 0; c < 3; c++) begin
      check("t6_rst_nodone", 32'(done), 0);
      @(negedge clk);
    end
    check_regs();

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      do_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
